// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch (IF) and data (DM)
// requesters: DM priority, bounded IF anti-starvation, per-transaction timeout.
module mem_port_arbiter #(
  parameter int W             = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic         clk,
  input  logic         rst,
  // instruction-fetch requester
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic         if_done,
  output logic [W-1:0] if_rdata,
  // data requester
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [3:0]   dm_be,
  input  logic [W-1:0] dm_addr,
  input  logic [W-1:0] dm_wdata,
  output logic         dm_done,
  output logic [W-1:0] dm_rdata,
  // external memory port
  output logic         mem_req,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  // status and pipeline stalls
  output logic         bus_err,
  output logic         stall_if,
  output logic         stall_dm
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [3:0] STREAK_SAT = 4'hF;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] streak;
  logic [7:0] timer;

  logic if_elig;
  logic dm_elig;
  logic grant_if;
  logic grant_dm;
  logic serving;
  logic timer_expired;

  // A requester still showing its done pulse is presenting the request that just finished.
  assign if_elig       = if_req & ~if_done;
  assign dm_elig       = dm_req & ~dm_done;
  assign serving       = (state != IDLE);
  assign timer_expired = (timer == TIMER_LAST);

  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_elig && (!if_elig || streak != STREAK_MAX)) begin
          grant_dm   = 1'b1;
          state_next = SERVE_DM;
        end else if (if_elig) begin
          grant_if   = 1'b1;
          state_next = SERVE_IF;
        end
      end
      SERVE_IF, SERVE_DM: begin
        if (mem_ack || timer_expired) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this block holds only control and data registers (no memory array),
      // so all of it is reset to give defined outputs straight after reset.
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      streak    <= 4'h0;
      timer     <= 8'h0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      bus_err <= 1'b0;

      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        timer     <= 8'h0;
        // Only DM grants won while IF is waiting count toward starving IF.
        if (!if_req) begin
          streak <= 4'h0;
        end else if (streak != STREAK_SAT) begin
          streak <= streak + 4'd1;
        end
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        timer     <= 8'h0;
        streak    <= 4'h0;
      end else if (serving) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (state == SERVE_DM) begin
            dm_rdata <= mem_rdata;
            dm_done  <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end else if (timer_expired) begin
          // Abort: the requester is released with zero data and an error flag.
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          if (state == SERVE_DM) begin
            dm_rdata <= '0;
            dm_done  <= 1'b1;
          end else begin
            if_rdata <= '0;
            if_done  <= 1'b1;
          end
        end else begin
          timer <= timer + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants and completions,
// a monitor pops and compares them whenever the port shows a new request or a done pulse.
module tb_mem_port_arbiter;

  localparam int W    = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic         clk;
  logic         rst;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_done;
  logic [W-1:0] if_rdata;
  logic         dm_req;
  logic         dm_we;
  logic [3:0]   dm_be;
  logic [W-1:0] dm_addr;
  logic [W-1:0] dm_wdata;
  logic         dm_done;
  logic [W-1:0] dm_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [3:0]   mem_be;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ack;
  logic         bus_err;
  logic         stall_if;
  logic         stall_dm;

  mem_port_arbiter #(.W(W), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        is_dm;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  grant_t      grant_q[$];
  done_t       done_q[$];
  logic [31:0] mem_img[logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  logic        ack_en    = 1'b1;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd);
    grant_q.push_back('{addr: a, we: we, be: be, wdata: wd});
  endtask

  task automatic push_done(input logic is_dm, input logic chk, input logic [31:0] rd,
                           input logic err);
    done_q.push_back('{is_dm: is_dm, chk_rdata: chk, rdata: rd, err: err});
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic wait_done(input logic want_dm, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (want_dm ? dm_done : if_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle memory: ack the cycle after mem_req rises; stray_ack injects an unsolicited ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      mem_ack   = stray_ack | (ack_en & rst & mem_req & ~mem_ack);
      mem_rdata = model_rdata(mem_addr);
    end
  end

  // Monitor: compares each new memory request and each done pulse against the queues.
  initial begin
    logic   prev_req;
    grant_t g;
    done_t  d;
    prev_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        prev_req = 1'b0;
        continue;
      end
      if (mem_req && !prev_req) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
        end else begin
          g = grant_q.pop_front();
          check("grant_addr", mem_addr, g.addr);
          check("grant_we", 32'(mem_we), 32'(g.we));
          check("grant_be", 32'(mem_be), 32'(g.be));
          check("grant_wdata", mem_wdata, g.wdata);
        end
      end
      prev_req = mem_req;
      if (if_done && dm_done) check("both_done", 32'd1, 32'd0);
      if (if_done || dm_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", {30'd0, dm_done, if_done}, 32'd0);
        end else begin
          d = done_q.pop_front();
          check("done_src_dm", 32'(dm_done), 32'(d.is_dm));
          if (d.chk_rdata) check("done_rdata", dm_done ? dm_rdata : if_rdata, d.rdata);
          check("done_bus_err", 32'(bus_err), 32'(d.err));
        end
      end else if (bus_err) begin
        check("bus_err_without_done", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hi;
    int  idx;
    bit  if_pending;
    bit  seen;

    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
    mem_img[32'h0000_0100] = 32'h2402_000A;
    mem_img[32'h0000_0104] = 32'h8C43_0004;
    mem_img[32'h0000_8000] = 32'hCAFE_F00D;
    mem_img[32'h0000_0200] = 32'h0085_1020;
    mem_img[32'h0000_0300] = 32'h1000_FFFF;

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", {30'd0, if_done, dm_done}, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst = 1'b1;

    // 1. IF only
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    push_grant(32'h100, 1'b0, 4'hF, 32'h0);
    push_done(1'b0, 1'b1, 32'h2402_000A, 1'b0);
    @(posedge clk); #1;
    check("t1_req_latency", 32'(mem_req), 32'd1);
    check("t1_stall_if_busy", 32'(stall_if), 32'd1);
    wait_done(1'b0, 10, "t1_if_done_seen");
    check("t1_stall_if_at_done", 32'(stall_if), 32'd0);
    @(negedge clk); if_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_if_rdata_hold", if_rdata, 32'h2402_000A);

    // Ack arriving while IDLE must not produce any completion.
    stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_ack_ignored", 32'(mem_req), 32'd0);

    // 2. Simultaneous requests: DM first, IF stalled throughout
    @(negedge clk);
    if_addr = 32'h104; if_req = 1'b1;
    dm_addr = 32'h8000; dm_we = 1'b0; dm_be = 4'hF; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
    push_grant(32'h8000, 1'b0, 4'hF, 32'h1234_5678);
    push_done(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
    push_grant(32'h104, 1'b0, 4'hF, 32'h0);
    push_done(1'b0, 1'b1, 32'h8C43_0004, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      check("t2_stall_if", 32'(stall_if), 32'd1);
      seen = dm_done;
    end
    check("t2_dm_done_seen", 32'(seen), 32'd1);
    check("t2_stall_dm_at_done", 32'(stall_dm), 32'd0);
    @(negedge clk); dm_req = 1'b0;
    wait_done(1'b0, 10, "t2_if_done_seen");
    @(negedge clk); if_req = 1'b0;

    // 3. Five stores against a waiting fetch. IF withdraws only during DM done cycles so DM
    //    can win consecutive slots; the streak guard must then hand the fifth slot to IF.
    for (int i = 0; i < 4; i++) push_grant(32'h1000 + 32'(4 * i), 1'b1, 4'hF, 32'h1111_0000 + 32'(i));
    push_grant(32'h200, 1'b0, 4'hF, 32'h0);
    push_grant(32'h1010, 1'b1, 4'hF, 32'h1111_0004);
    for (int i = 0; i < 4; i++) push_done(1'b1, 1'b0, 32'h0, 1'b0);
    push_done(1'b0, 1'b1, 32'h0085_1020, 1'b0);
    push_done(1'b1, 1'b0, 32'h0, 1'b0);
    idx = 0;
    if_pending = 1'b1;
    for (int cyc = 0; cyc < 200 && (idx < 5 || if_pending); cyc++) begin
      @(negedge clk);
      if (dm_done) idx++;
      if (if_done) if_pending = 1'b0;
      dm_req = (idx < 5);
      dm_we = 1'b1; dm_be = 4'hF;
      dm_addr = 32'h1000 + 32'(4 * idx);
      dm_wdata = 32'h1111_0000 + 32'(idx);
      if_addr = 32'h200;
      if_req = if_pending & ~dm_done;
    end
    check("t3_all_served", 32'(idx == 5 && !if_pending), 32'd1);
    dm_req = 1'b0; if_req = 1'b0;

    // 4. Partial store, held strobes
    @(negedge clk);
    dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hBEEF; dm_req = 1'b1;
    push_grant(32'h20, 1'b1, 4'h3, 32'hBEEF);
    push_done(1'b1, 1'b1, 32'hA5A5_0020, 1'b0);
    @(posedge clk); #1;
    check("t4_mem_we", 32'(mem_we), 32'd1);
    check("t4_mem_be", 32'(mem_be), 32'd3);
    check("t4_mem_wdata", mem_wdata, 32'hBEEF);
    wait_done(1'b1, 10, "t4_dm_done_seen");
    @(negedge clk); dm_req = 1'b0;
    repeat (3) @(negedge clk);

    // 5. No ack: abort after TMO cycles of mem_req
    ack_en = 1'b0;
    dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h40; dm_wdata = 32'h0; dm_req = 1'b1;
    push_grant(32'h40, 1'b0, 4'hF, 32'h0);
    push_done(1'b1, 1'b1, 32'h0, 1'b1);
    hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = dm_done;
      if (!seen && mem_req) hi++;
    end
    check("t5_done_seen", 32'(seen), 32'd1);
    check("t5_req_cycles", 32'(hi), 32'(TMO));
    check("t5_req_dropped", 32'(mem_req), 32'd0);
    @(negedge clk); dm_req = 1'b0; ack_en = 1'b1;
    @(posedge clk); #1;
    check("t5_bus_err_pulse", 32'(bus_err), 32'd0);
    check("t5_dm_rdata_zero", dm_rdata, 32'd0);

    // 6. Reset during SERVE_IF, then a clean retry
    @(negedge clk);
    ack_en = 1'b0; if_addr = 32'h300; if_req = 1'b1;
    push_grant(32'h300, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    check("t6_req_up", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_async_drop", 32'(mem_req), 32'd0);
    check("t6_no_if_done", 32'(if_done), 32'd0);
    check("t6_if_rdata_cleared", if_rdata, 32'd0);
    @(negedge clk); ack_en = 1'b1;
    push_grant(32'h300, 1'b0, 4'hF, 32'h0);
    push_done(1'b0, 1'b1, 32'h1000_FFFF, 1'b0);
    @(negedge clk); rst = 1'b1;
    wait_done(1'b0, 10, "t6_if_done_seen");
    @(negedge clk); if_req = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
